// File: rtl/dct_mac_sequencer_if.sv
// dct_mac_sequencer_if: handshake, LUT and pixel-buffer signals for one DCT coefficient MAC job.
//   slave  (sequencer): start_valid/k1/k2/cos_term/pix_data/coef_ready in;
//                       start_ready/k_sel/n1/n2/pix_rd/pix_addr/coef_valid/coef/busy out
//   master (environment): the mirror image
interface dct_mac_sequencer_if #(
    parameter int PIX_W = 8
);
    logic               start_valid;
    logic               start_ready;
    logic [2:0]         k1;
    logic [2:0]         k2;
    logic [5:0]         k_sel;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic signed [31:0] cos_term;
    logic               pix_rd;
    logic [5:0]         pix_addr;
    logic [PIX_W-1:0]   pix_data;
    logic               coef_valid;
    logic               coef_ready;
    logic signed [31:0] coef;
    logic               busy;

    modport slave (
        input  start_valid, k1, k2, cos_term, pix_data, coef_ready,
        output start_ready, k_sel, n1, n2, pix_rd, pix_addr, coef_valid, coef, busy
    );

    modport master (
        output start_valid, k1, k2, cos_term, pix_data, coef_ready,
        input  start_ready, k_sel, n1, n2, pix_rd, pix_addr, coef_valid, coef, busy
    );
endinterface

// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: walks 64 spatial indices, multiplies each pixel by its cosine term and
// accumulates one 2-D DCT coefficient, returned through a valid/ready handshake.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : dct_mac_sequencer_if.slave (job start, LUT index/term, pixel read, result)
module dct_mac_sequencer #(
    parameter int PIX_W       = 8,
    parameter int FRAC_BITS   = 8,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dct_mac_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             r_state;
    logic [5:0]         r_idx;
    logic [5:0]         r_k_sel;
    logic               r_v1;
    logic signed [31:0] r_cos_q;
    logic signed [31:0] r_acc;
    logic signed [31:0] w_p;
    logic signed [31:0] w_prod;

    assign w_p    = $signed({{(32-PIX_W){1'b0}}, bus.pix_data})
                  - ((LEVEL_SHIFT != 0) ? (32'sd1 <<< (PIX_W-1)) : 32'sd0);
    assign w_prod = r_cos_q * w_p;

    // r_idx stops at 63 rather than wrapping, so n1/n2 keep the last issued index outside RUN.
    assign bus.start_ready = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.pix_rd      = (r_state == RUN);
    assign bus.coef_valid  = (r_state == DONE);
    assign bus.coef        = (r_state == DONE) ? (r_acc >>> FRAC_BITS) : 32'sd0;
    assign bus.k_sel       = r_k_sel;
    assign bus.n1          = r_idx[5:3];
    assign bus.n2          = r_idx[2:0];
    assign bus.pix_addr    = r_idx;

    // Stage 1 registers the cosine term while the pixel read is in flight; the product is
    // accumulated one cycle later, so DRAIN absorbs the term for index 63.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_k_sel <= '0;
            r_v1    <= 1'b0;
            r_cos_q <= '0;
            r_acc   <= '0;
        end else begin
            if (r_v1)
                r_acc <= r_acc + w_prod;
            case (r_state)
                IDLE: if (bus.start_valid) begin
                    r_state <= RUN;
                    r_k_sel <= {bus.k1, bus.k2};
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_v1    <= 1'b0;
                end
                RUN: begin
                    r_cos_q <= bus.cos_term;
                    r_v1    <= 1'b1;
                    if (r_idx == 6'd63)
                        r_state <= DRAIN;
                    else
                        r_idx <= r_idx + 6'd1;
                end
                DRAIN: begin
                    r_v1    <= 1'b0;
                    r_state <= DONE;
                end
                DONE: if (bus.coef_ready)
                    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb_dct_mac_sequencer: directed checks of two sequencers (LEVEL_SHIFT=1 and =0) run in lockstep.
module tb_dct_mac_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       coef_ready = 1'b0;
    logic [2:0] k1 = '0;
    logic [2:0] k2 = '0;
    logic       lut_mode = 1'b0;
    int         pix_mode = 0;
    int         total = 0;
    int         bad = 0;
    logic signed [31:0] row [8] = '{32'sh0d4, -32'sh031, -32'sh0fb, -32'sh08e,
                                    32'sh08e, 32'sh0fb, 32'sh031, -32'sh0d4};

    dct_mac_sequencer_if #(.PIX_W(8)) a_if();
    dct_mac_sequencer_if #(.PIX_W(8)) b_if();

    dct_mac_sequencer #(.PIX_W(8), .FRAC_BITS(8), .LEVEL_SHIFT(1)) u_ls1 (.clk(clk), .rst_n(rst_n), .bus(a_if));
    dct_mac_sequencer #(.PIX_W(8), .FRAC_BITS(8), .LEVEL_SHIFT(0)) u_ls0 (.clk(clk), .rst_n(rst_n), .bus(b_if));

    always #5 clk = ~clk;

    assign a_if.start_valid = start_valid;
    assign b_if.start_valid = start_valid;
    assign a_if.k1 = k1;
    assign b_if.k1 = k1;
    assign a_if.k2 = k2;
    assign b_if.k2 = k2;
    assign a_if.coef_ready = coef_ready;
    assign b_if.coef_ready = coef_ready;
    assign a_if.cos_term = lut_mode ? row[a_if.n2] : 32'sd32;
    assign b_if.cos_term = lut_mode ? row[b_if.n2] : 32'sd32;

    function automatic logic [7:0] pix(input logic [5:0] a);
        case (pix_mode)
            0:       return 8'd255;
            1:       return 8'd1;
            2:       return (a[2:0] == 3'd0) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (a_if.pix_rd) a_if.pix_data <= pix(a_if.pix_addr);
        if (b_if.pix_rd) b_if.pix_data <= pix(b_if.pix_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [2:0] k1v, input logic [2:0] k2v);
        @(negedge clk);
        k1 = k1v;
        k2 = k2v;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Called at acceptance edge + 1; counts edges until coef_valid and checks the address walk.
    task automatic wait_done(input string tag);
        int edges = 0;
        int nexp = 0;
        int seq_bad = 0;
        logic [5:0] want;
        while (!a_if.coef_valid && edges < 200) begin
            if (a_if.pix_rd) begin
                want = nexp[5:0];
                if (a_if.pix_addr !== want || nexp > 63) seq_bad++;
                nexp++;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_lat"}, edges, 65);
        chk({tag, "_addr_seq"}, seq_bad, 0);
        chk({tag, "_addr_cnt"}, nexp, 64);
        chk({tag, "_b_valid"}, b_if.coef_valid, 1);
    endtask

    task automatic release_done(input string tag);
        @(negedge clk);
        coef_ready = 1'b1;
        @(posedge clk);
        #1;
        coef_ready = 1'b0;
        chk({tag, "_idle"}, {a_if.start_ready, a_if.busy, a_if.coef_valid}, 3'b100);
    endtask

    // {start_ready, busy, coef_valid, pix_rd, n1, n2, k_sel} at reset
    localparam logic [15:0] RST_VEC = 16'h8000;

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, last_acc, n_acc;
        logic was_ready;
        logic [5:0] kv;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", {a_if.start_ready, a_if.busy, a_if.coef_valid, a_if.pix_rd, a_if.n1, a_if.n2, a_if.k_sel}, RST_VEC);
        chk("rst_b", {b_if.start_ready, b_if.busy, b_if.coef_valid, b_if.pix_rd, b_if.n1, b_if.n2, b_if.k_sel}, RST_VEC);
        chk("rst_coef", a_if.coef, 0);
        @(negedge clk);
        rst_n = 1'b1;
        coef_ready = 1'b1;
        @(posedge clk);
        #1;
        coef_ready = 1'b0;
        chk("ready_in_idle", {a_if.start_ready, a_if.busy, a_if.coef_valid}, 3'b100);

        // constant cos 32, pixels 255: 127*32*64>>>8 and 255*32*64>>>8
        lut_mode = 1'b0; pix_mode = 0;
        accept(3'd0, 3'd0);
        wait_done("dc");
        chk("dc_coef_ls1", a_if.coef, 1016);
        chk("dc_coef_ls0", b_if.coef, 2040);
        chk("dc_ksel", a_if.k_sel, 6'o00);
        release_done("dc");

        // k=(0,3) row, pixels 1: row sums to zero
        lut_mode = 1'b1; pix_mode = 1;
        accept(3'd0, 3'd3);
        wait_done("flat");
        chk("flat_coef_ls0", b_if.coef, 0);
        chk("flat_coef_ls1", a_if.coef, 0);
        chk("flat_ksel", a_if.k_sel, 6'o03);
        release_done("flat");

        // pixel 1 only at n2=0: 8*0xd4=1696 -> 6 (same for level-shifted -127/-128 pixels)
        pix_mode = 2;
        accept(3'd0, 3'd3);
        wait_done("col");
        chk("col_coef_ls0", b_if.coef, 6);
        chk("col_coef_ls1", a_if.coef, 6);

        // backpressure: start requests ignored while DONE is held
        @(negedge clk);
        k1 = 3'd5; k2 = 3'd5; start_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_coef", a_if.coef, 6);
        chk("bp_state", {a_if.busy, a_if.coef_valid, a_if.start_ready}, 3'b110);
        chk("bp_ksel", a_if.k_sel, 6'o03);
        @(negedge clk);
        k1 = 3'd7; k2 = 3'd1; coef_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {a_if.start_ready, a_if.busy, a_if.coef_valid}, 3'b100);
        @(posedge clk);
        #1;
        coef_ready = 1'b0;
        start_valid = 1'b0;
        chk("bp_reaccept", {a_if.busy, a_if.k_sel}, {1'b1, 6'o71});
        wait_done("bp2");
        chk("bp2_coef", a_if.coef, 6);
        release_done("bp2");

        // all-zero pixels, level shift -128: negative arithmetic shift
        lut_mode = 1'b0; pix_mode = 3;
        accept(3'd1, 3'd2);
        wait_done("neg");
        chk("neg_coef_ls1", a_if.coef, 32'hFFFFFC00);
        chk("neg_coef_ls0", b_if.coef, 0);
        release_done("neg");

        // reset at idx=30
        lut_mode = 1'b1; pix_mode = 2;
        accept(3'd2, 3'd4);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_idx", a_if.pix_addr, 30);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", {a_if.start_ready, a_if.busy, a_if.coef_valid, a_if.pix_rd, a_if.n1, a_if.n2, a_if.k_sel}, RST_VEC);
        chk("mid_rst_b", {b_if.start_ready, b_if.busy, b_if.coef_valid, b_if.pix_rd, b_if.n1, b_if.n2, b_if.k_sel}, RST_VEC);
        chk("mid_rst_coef", a_if.coef, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", {a_if.start_ready, a_if.coef_valid}, 2'b10);
        accept(3'd2, 3'd4);
        wait_done("rerun");
        chk("rerun_coef_ls1", a_if.coef, 6);
        chk("rerun_coef_ls0", b_if.coef, 6);
        release_done("rerun");

        // continuous start with random k: one job every 67 cycles
        lut_mode = 1'b0; pix_mode = 0;
        coef_ready = 1'b1;
        last_acc = -1;
        n_acc = 0;
        for (cyc = 1; cyc <= 210; cyc++) begin
            @(negedge clk);
            k1 = 3'($urandom_range(7));
            k2 = 3'($urandom_range(7));
            kv = {k1, k2};
            start_valid = 1'b1;
            was_ready = a_if.start_ready;
            @(posedge clk);
            #1;
            if (a_if.coef_valid) chk("cont_coef", a_if.coef, 1016);
            if (was_ready) begin
                n_acc++;
                chk("cont_ksel", a_if.k_sel, kv);
                if (last_acc >= 0) chk("cont_period", cyc - last_acc, 67);
                last_acc = cyc;
            end
        end
        start_valid = 1'b0;
        coef_ready = 1'b0;
        chk("cont_accepts", n_acc, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
